// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte-oriented UART transmitter with an internal TX FIFO. It drives the
// top-level uart_tx pin and is the transmit counterpart of the uart_rx path.
// A frame is one start bit (0), eight data bits LSB first, an optional parity
// bit, and STOP_BITS stop bits (1). The line idles high.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 4); default 100 MHz / 9600
//   FIFO_DEPTH    TX FIFO entries, power of two, 2..256
//   STOP_BITS     number of stop bits, 1 or 2
//   PARITY_ODD    parity sense (0 = even, 1 = odd); used only with parity
//
// Build option
//   UART_TX_PARITY_EN  when defined, a parity bit follows the data bits
//                      (8E1 / 8O1). When undefined the frame is 8N1 and no
//                      parity logic exists.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   tx_data     in   byte to transmit
//   tx_valid    in   tx_data is valid
//   tx_ready    out  FIFO can accept a byte (not full)
//   uart_tx     out  serial line, driven from a flop
//   tx_busy     out  high while a frame is on the line
//   tx_done     out  one-cycle pulse in the last cycle of the final stop bit
//   fifo_level  out  FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [2:0]       DATA_LAST = 3'd7;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_SENSE = 1'(PARITY_ODD);

    // Parity of one data byte, inverted for odd parity.
    function automatic logic parity_of(input logic [7:0] b);
        return (^b) ^ PARITY_SENSE;
    endfunction
`else
    // Without the parity stage PARITY_ODD has no effect; only its range is
    // referenced here so the parameter remains part of the interface.
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_parity_odd_out_of_range
    end
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [7:0]       head_s;

    // ------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------
    state_t           state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             uart_tx_r;
    logic             tx_busy_r;
    logic             tx_done_r;
`ifdef UART_TX_PARITY_EN
    logic             parity_r;
`endif

    logic             baud_term_s;
    logic             stop_end_s;
    logic             line_s;

    // FIFO flags, handshake and the pop request from the transmitter.
    always_comb begin
        full_s      = (level_r == LVL_FULL);
        empty_s     = (level_r == LVL_ZERO);
        tx_ready    = ~full_s;
        push_s      = tx_valid & ~full_s;
        head_s      = mem_r[rd_ptr_r];
        baud_term_s = (baud_cnt_r == BAUD_LAST);
        stop_end_s  = 1'b0;
        pop_s       = 1'b0;
        if ((state_r == ST_STOP) && baud_term_s && (bit_cnt_r == STOP_LAST)) begin
            stop_end_s = 1'b1;
        end else begin
            stop_end_s = 1'b0;
        end
        // A new frame is loaded either from idle or straight out of the
        // final stop cycle, which keeps back-to-back frames gap-free.
        if (!empty_s && ((state_r == ST_IDLE) || stop_end_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next line level as a function of the current state; registered below
    // so the pin only ever changes on a clock edge.
    always_comb begin
        line_s = 1'b1;
        case (state_r)
            ST_IDLE:   line_s = 1'b1;
            ST_START:  line_s = 1'b0;
            ST_DATA:   line_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_s = parity_r;
`endif
            ST_STOP:   line_s = 1'b1;
            default:   line_s = 1'b1;
        endcase
    end

    // FIFO data array; contents need no reset because level gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame sequencer with registered line, busy and done outputs. The
    // outputs follow the state by one cycle, so a byte written into an idle
    // empty FIFO at edge N pulls the line low from edge N+2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            uart_tx_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            uart_tx_r <= line_s;
            tx_busy_r <= (state_r != ST_IDLE);
            tx_done_r <= stop_end_s;

            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= {CNT_W{1'b0}};
                    bit_cnt_r  <= 3'd0;
                    if (pop_s) begin
                        shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                        parity_r <= parity_of(head_s);
`endif
                        state_r  <= ST_START;
                    end
                end

                ST_START: begin
                    if (baud_term_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        bit_cnt_r  <= 3'd0;
                        state_r    <= ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (baud_term_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        shift_r    <= {1'b0, shift_r[7:1]};
                        if (bit_cnt_r == DATA_LAST) begin
                            bit_cnt_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_r   <= ST_PARITY;
`else
                            state_r   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_term_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        bit_cnt_r  <= 3'd0;
                        state_r    <= ST_STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    // bit_cnt_r counts stop bits here when STOP_BITS is 2.
                    if (baud_term_s) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        if (bit_cnt_r == STOP_LAST) begin
                            bit_cnt_r <= 3'd0;
                            if (pop_s) begin
                                shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                                parity_r <= parity_of(head_s);
`endif
                                state_r  <= ST_START;
                            end else begin
                                state_r  <= ST_IDLE;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= {CNT_W{1'b0}};
                    bit_cnt_r  <= 3'd0;
                end
            endcase
        end
    end

    assign uart_tx    = uart_tx_r;
    assign tx_busy    = tx_busy_r;
    assign tx_done    = tx_done_r;
    assign fifo_level = level_r;

endmodule
